// File: rtl/sched_pkg.sv
// Shared types and default widths for the strobe scheduler.
package sched_pkg;

  // Config FSM: IDLE accepts a request, APPLY commits it one cycle later.
  typedef enum logic [0:0] {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_e;

  // Channel run mode.
  typedef enum logic [0:0] {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } ch_mode_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 2;
  localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: divides the shared base tick by a programmable ratio,
// periodic or one-shot. A commit always wins over a same-cycle terminal count.
module strobe_channel
  import sched_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             base_tick,
  input  logic             commit,
  input  logic [DIV_W-1:0] commit_div,
  input  ch_mode_e         commit_mode,
  input  logic             enable,
  output logic             tick,
  output logic             busy
);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  ch_mode_e         mode_reg, mode_next;
  logic             armed_reg, armed_next;
  logic             tick_reg, tick_next;
  logic             busy_reg;
  logic             active;
  logic             terminal;

  // div-1 is only evaluated while div is nonzero, so it never underflows
  assign active   = armed_reg & enable & (div_reg != '0);
  assign terminal = active & base_tick & (cnt_reg == (div_reg - DIV_W'(1)));

  // Next-state: commit, hold-at-zero when inactive, or count base ticks
  always_comb begin
    div_next   = div_reg;
    mode_next  = mode_reg;
    armed_next = armed_reg;
    cnt_next   = cnt_reg;
    tick_next  = 1'b0;
    if (commit) begin
      div_next   = commit_div;
      mode_next  = commit_mode;
      armed_next = 1'b1;
      cnt_next   = '0;
    end else if (!active) begin
      cnt_next = '0;
    end else if (base_tick) begin
      if (terminal) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (mode_reg == MODE_ONESHOT) begin
          armed_next = 1'b0;
        end
      end else begin
        cnt_next = cnt_reg + DIV_W'(1);
      end
    end
  end

  // State registers; busy is taken from next-state so it drops with the final tick
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= '0;
      mode_reg  <= MODE_PERIODIC;
      armed_reg <= 1'b0;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      div_reg   <= div_next;
      mode_reg  <= mode_next;
      armed_reg <= armed_next;
      cnt_reg   <= cnt_next;
      tick_reg  <= tick_next;
      busy_reg  <= armed_next & enable & (div_next != '0);
    end
  end

  assign tick = tick_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/strobe_scheduler.sv
// Multi-channel periodic/one-shot strobe scheduler: shared prescaler, a
// two-state config FSM and NUM_CH strobe_channel instances.
// Optional macro SCHED_BAD_CFG_EN adds a sticky cfg_err output flagging
// commits that target a nonexistent channel.
module strobe_scheduler
  import sched_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int PRESCALE = 100,
  parameter  int DIV_W    = DEF_DIV_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
`ifdef SCHED_BAD_CFG_EN
  ,
  output logic              cfg_err
`endif
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]  presc_reg;
  logic             base_tick_reg;
  cfg_state_e       state_reg, state_next;
  logic [CH_W-1:0]  hold_ch_reg;
  logic [DIV_W-1:0] hold_div_reg;
  ch_mode_e         hold_mode_reg;

  // Prescaler: count 0..PRESCALE-1, base tick registered off the wrap value
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg     <= '0;
      base_tick_reg <= 1'b0;
    end else begin
      base_tick_reg <= (presc_reg == PS_W'(PRESCALE - 1));
      if (presc_reg == PS_W'(PRESCALE - 1)) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + PS_W'(1);
      end
    end
  end

  assign base_tick = base_tick_reg;

  // Config FSM transitions: APPLY always lasts exactly one cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG_IDLE:  if (cfg_valid) state_next = CFG_APPLY;
      CFG_APPLY: state_next = CFG_IDLE;
      default:   state_next = CFG_IDLE;
    endcase
  end

  // FSM state and request holding registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CFG_IDLE;
      hold_ch_reg   <= '0;
      hold_div_reg  <= '0;
      hold_mode_reg <= MODE_PERIODIC;
    end else begin
      state_reg <= state_next;
      if (state_reg == CFG_IDLE && cfg_valid) begin
        hold_ch_reg   <= cfg_ch;
        hold_div_reg  <= cfg_div;
        hold_mode_reg <= cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
      end
    end
  end

  assign cfg_ready = (state_reg == CFG_IDLE);

  // One channel per index; an out-of-range hold_ch matches no instance
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic commit;
    assign commit = (state_reg == CFG_APPLY) && (hold_ch_reg == CH_W'(gi));

    strobe_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .base_tick  (base_tick_reg),
      .commit     (commit),
      .commit_div (hold_div_reg),
      .commit_mode(hold_mode_reg),
      .enable     (ch_enable[gi]),
      .tick       (tick[gi]),
      .busy       (busy[gi])
    );
  end

`ifdef SCHED_BAD_CFG_EN
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic cfg_err_reg;
  logic ch_in_range;

  assign ch_in_range = ({1'b0, hold_ch_reg} < NUM_CH_L);

  // Sticky error for a commit aimed past the last channel
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_reg <= 1'b0;
    end else if (state_reg == CFG_APPLY && !ch_in_range) begin
      cfg_err_reg <= 1'b1;
    end
  end

  assign cfg_err = cfg_err_reg;
`endif

endmodule

// File: tb/tb_strobe_scheduler.sv
// Self-checking bench for strobe_scheduler (PRESCALE=4, NUM_CH=4, DIV_W=8).
// The reference model counts base ticks seen by each active channel since
// its last commit/restart and expects a tick whenever that count is a
// multiple of the ratio.
`timescale 1ns/1ps
module tb_strobe_scheduler;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int DIV_W    = 8;
  localparam int CH_W     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic              base_tick;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
`ifdef SCHED_BAD_CFG_EN
  logic              cfg_err;
  logic              r2 = 1'b1;
  logic              v2 = 1'b0;
  logic [1:0]        c2 = '0;
  logic [DIV_W-1:0]  d2 = '0;
  logic              rdy2, bt2, err2;
  logic [2:0]        tick2, busy2;
`endif

  always #5 clk = ~clk;

  strobe_scheduler #(
    .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .ch_enable(ch_enable), .base_tick(base_tick), .tick(tick), .busy(busy)
`ifdef SCHED_BAD_CFG_EN
    , .cfg_err(cfg_err)
`endif
  );

`ifdef SCHED_BAD_CFG_EN
  strobe_scheduler #(
    .NUM_CH(3), .PRESCALE(PRESCALE), .DIV_W(DIV_W)
  ) dut3 (
    .clk(clk), .reset(r2), .cfg_valid(v2), .cfg_ready(rdy2),
    .cfg_ch(c2), .cfg_div(d2), .cfg_oneshot(1'b0),
    .ch_enable(3'b111), .base_tick(bt2), .tick(tick2), .busy(busy2),
    .cfg_err(err2)
  );
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int                k;
  bit                m_base;
  bit                m_pending;
  int                m_hch, m_hdiv;
  bit                m_hos;
  bit                m_armed [NUM_CH];
  int                m_div   [NUM_CH];
  bit                m_os    [NUM_CH];
  int                m_nbt   [NUM_CH];
  bit [NUM_CH-1:0]   m_tick, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  // Advance the model over one clock edge using the inputs currently driven
  task automatic model_edge();
    bit commit_i, act;
    if (reset) begin
      k = 0; m_base = 0; m_pending = 0; m_tick = '0; m_busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_armed[i] = 0; m_div[i] = 0; m_os[i] = 0; m_nbt[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      commit_i  = m_pending && (m_hch == i);
      act       = m_armed[i] && ch_enable[i] && (m_div[i] != 0);
      m_tick[i] = 1'b0;
      if (commit_i) begin
        m_div[i] = m_hdiv; m_os[i] = m_hos; m_armed[i] = 1; m_nbt[i] = 0;
      end else if (!act) begin
        m_nbt[i] = 0;
      end else if (m_base) begin
        m_nbt[i]++;
        if (m_nbt[i] % m_div[i] == 0) begin
          m_tick[i] = 1'b1;
          if (m_os[i]) m_armed[i] = 0;
        end
      end
      m_busy[i] = m_armed[i] && ch_enable[i] && (m_div[i] != 0);
    end
    if (m_pending) begin
      m_pending = 0;
    end else if (cfg_valid) begin
      m_pending = 1; m_hch = int'(cfg_ch); m_hdiv = int'(cfg_div); m_hos = cfg_oneshot;
    end
    k++;
    m_base = (k % PRESCALE == 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("base_tick", 32'(base_tick), 32'(m_base));
    check("tick", 32'(tick), 32'(m_tick));
    check("busy", 32'(busy), 32'(m_busy));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
`ifdef SCHED_BAD_CFG_EN
    check("cfg_err", 32'(cfg_err), 32'(0));
`endif
  endtask

  task automatic drive_cfg(input int ch, input int div, input bit os);
    cfg_valid   = 1'b1;
    cfg_ch      = CH_W'(ch);
    cfg_div     = DIV_W'(div);
    cfg_oneshot = os;
    $display("cfg  cycle=%0d ch=%0d div=%0d oneshot=%0d", k, ch, div, os);
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < maxc);
    check($sformatf("wait_tick_ch%0d", ch), 32'(tick[ch]), 32'(1));
  endtask

  initial begin
    int n, cnt;

    // Reset and idle prescaler
    repeat (3) step();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("t1_base_phase", 32'(base_tick), 32'(i % 4 == 0));
    end

    // Periodic ch0, ratio 3
    ch_enable[0] = 1'b1;
    drive_cfg(0, 3, 1'b0);
    step();
    cfg_valid = 1'b0;
    wait_tick(0, 40, n);
    wait_tick(0, 40, n);
    $display("tick ch0 period=%0d", n);
    check("t2_period", 32'(n), 32'(12));

    // One-shot ch1, ratio 2
    ch_enable[1] = 1'b1;
    drive_cfg(1, 2, 1'b1);
    step();
    cfg_valid = 1'b0;
    wait_tick(1, 40, n);
    check("t3_busy_fall", 32'(busy[1]), 32'(0));
    cnt = 0;
    repeat (40) begin
      step();
      if (tick[1]) cnt++;
    end
    check("t3_no_retick", 32'(cnt), 32'(0));

    // Reprogram ch0 so the commit lands on its terminal base tick
    n = 0;
    while (!(((k + 1) % PRESCALE == 0) && (m_nbt[0] % 3 == 2) && !m_pending) && n < 60) begin
      step();
      n++;
    end
    drive_cfg(0, 5, 1'b0);
    step();
    cfg_valid = 1'b0;
    check("t4_aligned_base", 32'(base_tick), 32'(1));
    step();
    check("t4_no_tick_at_commit", 32'(tick[0]), 32'(0));
    wait_tick(0, 40, n);
    check("t4_gap", 32'(n), 32'(20));

    // ch2 with ratio 0 stays idle; restore ch0 to ratio 3
    ch_enable[2] = 1'b1;
    drive_cfg(2, 0, 1'b0);
    step();
    cfg_valid = 1'b0;
    step();
    drive_cfg(0, 3, 1'b0);
    step();
    cfg_valid = 1'b0;
    cnt = 0;
    repeat (16) begin
      step();
      if (tick[2]) cnt++;
    end
    check("t5_ch2_ticks", 32'(cnt), 32'(0));
    check("t5_ch2_busy", 32'(busy[2]), 32'(0));

    // Drop ch0 enable, then restart just after a base tick
    ch_enable[0] = 1'b0;
    repeat (6) step();
    n = 0;
    while (k % PRESCALE != 1 && n < 8) begin
      step();
      n++;
    end
    ch_enable[0] = 1'b1;
    wait_tick(0, 40, n);
    check("t5_restart", 32'(n), 32'(12));

    // Back-to-back requests
    ch_enable = 4'b1111;
    drive_cfg(3, 1, 1'b0);
    step();
    check("t6_ready_a", 32'(cfg_ready), 32'(0));
    drive_cfg(2, 2, 1'b0);
    step();
    check("t6_ready_b", 32'(cfg_ready), 32'(1));
    step();
    check("t6_ready_c", 32'(cfg_ready), 32'(0));
    cfg_valid = 1'b0;
    step();
    check("t6_ready_d", 32'(cfg_ready), 32'(1));
    step();
    check("t6_busy32", 32'(busy[3:2]), 32'(2'b11));

    // Reset during APPLY discards the pending request
    drive_cfg(1, 1, 1'b0);
    step();
    cfg_valid = 1'b0;
    reset = 1'b1;
    step();
    check("t6_rst_tick", 32'(tick), 32'(0));
    check("t6_rst_busy", 32'(busy), 32'(0));
    check("t6_rst_base", 32'(base_tick), 32'(0));
    check("t6_rst_ready", 32'(cfg_ready), 32'(1));
    reset = 1'b0;
    repeat (10) step();
    check("t6_cfg_lost", 32'(busy[1]), 32'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_ch      = CH_W'($urandom);
      cfg_div     = DIV_W'($urandom_range(0, 4));
      cfg_oneshot = 1'($urandom);
      if ($urandom_range(0, 15) == 0) ch_enable = NUM_CH'($urandom);
      if (cfg_valid && !m_pending && !reset)
        $display("cfg  cycle=%0d ch=%0d div=%0d oneshot=%0d (random)", k, cfg_ch, cfg_div, cfg_oneshot);
      step();
    end
    reset = 1'b0;
    cfg_valid = 1'b0;
    repeat (4) step();

`ifdef SCHED_BAD_CFG_EN
    // Out-of-range channel on a 3-channel instance
    @(posedge clk); #1;
    r2 = 1'b0;
    v2 = 1'b1; c2 = 2'd3; d2 = 8'd1;
    $display("cfg  dut3 ch=3 div=1 (out of range)");
    @(posedge clk); #1;
    v2 = 1'b0;
    vectors++;
    check("bad_err_before_apply", 32'(err2), 32'(0));
    @(posedge clk); #1;
    check("bad_err_set", 32'(err2), 32'(1));
    repeat (5) @(posedge clk);
    #1;
    check("bad_err_sticky", 32'(err2), 32'(1));
    check("bad_no_busy", 32'(busy2), 32'(0));
    r2 = 1'b1;
    @(posedge clk); #1;
    check("bad_err_reset", 32'(err2), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
